// File: rtl/i2c_regbank_ctrl_if.sv
// I2C slave byte stream and local write port of the register bank, grouped for i2c_regbank_ctrl.
// master drives bus events and local writes; slave (the bank) returns tx_data, strobes and collisions.
interface i2c_regbank_ctrl_if #(
  parameter int PTR_W = 4
) ();
  logic             bus_start;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             tx_req;
  logic [7:0]       tx_data;
  logic             lcl_we;
  logic [PTR_W-1:0] lcl_addr;
  logic [7:0]       lcl_wdata;
  logic             lcl_collide;
  logic             wr_strobe;
  logic [PTR_W-1:0] wr_index;

  modport master (
    output bus_start, rx_valid, rx_data, tx_req, lcl_we, lcl_addr, lcl_wdata,
    input  tx_data, lcl_collide, wr_strobe, wr_index
  );

  modport slave (
    input  bus_start, rx_valid, rx_data, tx_req, lcl_we, lcl_addr, lcl_wdata,
    output tx_data, lcl_collide, wr_strobe, wr_index
  );
endinterface

// File: rtl/i2c_regbank_ctrl.sv
// Pointer-addressed register bank behind an I2C slave plus a local write port; all outputs registered, 1-cycle latency, no stalls.
// Optional I2C_REGBANK_WPROT_EN adds a wprot input that blocks I2C data writes while the pointer keeps stepping.
module i2c_regbank_ctrl #(
  parameter int                    NUM_REGS  = 16,
  parameter int                    PTR_W     = 4,
  parameter logic [8*NUM_REGS-1:0] RESET_VAL = {NUM_REGS{8'h00}}
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef I2C_REGBANK_WPROT_EN
  input  logic                  wprot,
`endif
  i2c_regbank_ctrl_if.slave     bus,
  output logic [8*NUM_REGS-1:0] reg_q,
  output logic [PTR_W-1:0]      ptr
);

  typedef enum logic {
    ST_PTR  = 1'b0,
    ST_DATA = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [PTR_W-1:0] ptr_d;
  logic             i2c_wr;
  logic             collide;
  logic             wr_allow;
  logic [7:0]       regs [NUM_REGS];

`ifdef I2C_REGBANK_WPROT_EN
  assign wr_allow = ~wprot;
`else
  assign wr_allow = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_PTR;
      ptr     <= '0;
    end else begin
      state_q <= state_d;
      ptr     <= ptr_d;
    end
  end

  // bus_start outranks rx_valid, which outranks tx_req
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr;
    i2c_wr  = 1'b0;
    if (bus.bus_start) begin
      state_d = ST_PTR;
    end else if (bus.rx_valid) begin
      if (state_q == ST_PTR) begin
        ptr_d   = bus.rx_data[PTR_W-1:0];
        state_d = ST_DATA;
      end else begin
        i2c_wr = wr_allow;
        ptr_d  = ptr + PTR_W'(1);
      end
    end else if (bus.tx_req) begin
      ptr_d   = ptr + PTR_W'(1);
      state_d = ST_DATA;
    end
  end

  assign collide = i2c_wr && bus.lcl_we && (bus.lcl_addr == ptr);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VAL[8*i +: 8];
      end
    end else begin
      if (bus.lcl_we && !collide) begin
        regs[bus.lcl_addr] <= bus.lcl_wdata;
      end
      if (i2c_wr) begin
        regs[ptr] <= bus.rx_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.tx_data     <= 8'h00;
      bus.wr_strobe   <= 1'b0;
      bus.wr_index    <= '0;
      bus.lcl_collide <= 1'b0;
    end else begin
      bus.tx_data     <= regs[ptr];
      bus.wr_strobe   <= i2c_wr;
      bus.lcl_collide <= collide;
      if (i2c_wr) begin
        bus.wr_index <= ptr;
      end
    end
  end

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_q[8*i +: 8] = regs[i];
    end
  end

endmodule
